// File: rtl/prbs_pkg.sv
// Shared definitions for the serial PRBS checker: state encoding and the
// default predictor geometry matching the upstream 8-bit LFSR generator.
package prbs_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SEED   = 2'd0;
    localparam state_t VERIFY = 2'd1;
    localparam state_t LOCKED = 2'd2;

    localparam int        DEFAULT_N    = 8;
    localparam logic [7:0] DEFAULT_TAPS = 8'b10101000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that still honours a
// coincident increment (clear + inc leaves the counter at 1).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds its predictor from the line,
// verifies a run of predictions, then flywheels and counts bit errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int           N           = DEFAULT_N,
    parameter logic [N-1:0] TAPS        = N'(DEFAULT_TAPS),
    parameter int           LOCK_COUNT  = 16,
    parameter int           UNLOCK_ERRS = 4,
    parameter int           GOOD_RUN    = 64,
    parameter int           CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [7:0]       relock_count
);

    localparam int SW = $clog2(N + 1);

    state_t        state;
    logic [N-1:0]  r;
    logic [SW-1:0] seed_cnt;
    logic [7:0]    run;
    logic [7:0]    good_run;
    logic [3:0]    tally;

    logic pred;
    logic match;
    logic r_zero;
    logic err_inc;
    logic bit_inc;
    logic relock_inc;

    always_comb begin
        pred       = ^(r & TAPS);
        match      = (bit_in == pred);
        r_zero     = (r == '0);
        bit_inc    = bit_valid && (state == LOCKED);
        err_inc    = bit_inc && !match;
        relock_inc = err_inc && (tally == 4'(UNLOCK_ERRS - 1));
    end

    // In LOCKED the predictor feeds itself, so line errors never pollute it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEED;
            r         <= '0;
            seed_cnt  <= '0;
            run       <= '0;
            good_run  <= '0;
            tally     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_inc;
            if (bit_valid) begin
                case (state)
                    SEED: begin
                        r <= {r[N-2:0], bit_in};
                        if (seed_cnt == SW'(N - 1)) begin
                            seed_cnt <= '0;
                            run      <= '0;
                            state    <= VERIFY;
                        end else begin
                            seed_cnt <= seed_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        r <= {r[N-2:0], bit_in};
                        // An all-zero register predicts zeros forever; refuse it.
                        if (match && !r_zero) begin
                            if (run == 8'(LOCK_COUNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_run <= '0;
                                tally    <= '0;
                            end else begin
                                run <= run + 8'd1;
                            end
                        end else begin
                            seed_cnt <= '0;
                            state    <= SEED;
                        end
                    end
                    LOCKED: begin
                        r <= {r[N-2:0], pred};
                        if (!match) begin
                            good_run <= '0;
                            if (relock_inc) begin
                                state    <= SEED;
                                locked   <= 1'b0;
                                seed_cnt <= '0;
                                tally    <= '0;
                            end else begin
                                tally <= tally + 4'd1;
                            end
                        end else if (good_run == 8'(GOOD_RUN - 1)) begin
                            good_run <= '0;
                            tally    <= '0;
                        end else begin
                            good_run <= good_run + 8'd1;
                        end
                    end
                    default: begin
                        state <= SEED;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_inc),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (bit_inc),
        .q     (bit_count)
    );

    sat_counter #(.W(8)) u_relock_count (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (relock_inc),
        .q     (relock_count)
    );

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that sits directly downstream of the 8-bit LFSR pattern generator and consumes its one-bit-per-clock output stream. It self-synchronises to the incoming sequence and declares lock after a run of correctly predicted bits. Once locked, it flywheels its own predictor and counts bit errors and checked bits for link and bring-up testing.

## Interface
Parameters:
- N, 8, predictor register width
- TAPS, 8'b10101000, feedback mask; predicted bit = XOR-reduce(r & TAPS)
- LOCK_COUNT, 16, consecutive correct predictions required to lock (1..255)
- UNLOCK_ERRS, 4, errors inside one good-run window that force relock (1..15)
- GOOD_RUN, 64, consecutive good bits that clear the unlock error tally (1..255)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; all state and outputs cleared
- bit_in  in  1  received serial bit
- bit_valid  in  1  bit_in is sampled only when high
- clear  in  1  zero err_count and bit_count; lock state unaffected
- locked  out  1  checker is locked
- err_pulse  out  1  one-cycle pulse per mismatched bit while locked
- err_count  out  CNT_W  saturating count of errors while locked
- bit_count  out  CNT_W  saturating count of bits checked while locked
- relock_count  out  8  saturating count of LOCKED->SEED transitions

## Operation
- Predictor register r[N-1:0]; r[0] is the newest bit. Shift on every accepted bit: r <= {r[N-2:0], d}.
- pred = ^(r & TAPS); match = (bit_in == pred). Both are evaluated only on bit_valid.
- States:
  - SEED: d = bit_in. A seed counter counts N accepted bits, then goes to VERIFY with run = 0.
  - VERIFY: d = bit_in. On match, run++. On mismatch, go to SEED. If r == 0, treat as a mismatch, which prevents false lock on an all-zero stream. When run reaches LOCK_COUNT, go to LOCKED.
  - LOCKED (flywheel): d = pred, so a received error does not corrupt the predictor.
    - Every accepted bit: bit_count++.
    - On mismatch: err_count++, err_pulse, tally++, good run reset.
    - On match: good run++. When it reaches GOOD_RUN, tally = 0.
    - When tally reaches UNLOCK_ERRS, go to SEED and increment relock_count.
- bit_valid low: nothing advances; outputs hold, except err_pulse, which is 0.
- Counters saturate at all-ones and never wrap.
- clear in the same cycle as an increment: the counter takes the increment value (0 or 1), not the old value + 1.
- Reset values: locked = 0, err_pulse = 0, all counters 0, r = 0, state SEED.
- Reset mid-stream: the next accepted bit is seed bit 1.

## Timing
- All outputs are registered.
- err_pulse and counter updates are visible the cycle after the accepted bit.
- locked rises the cycle after the LOCK_COUNT-th consecutive match.
- locked falls the cycle after the UNLOCK_ERRS-th error.
- Minimum lock latency is N + LOCK_COUNT accepted bits (24 with defaults).
- The bit that triggers lock is not counted; counting starts with the next accepted bit.
- The bit that triggers unlock is counted as an error.
- No backpressure: every bit_valid cycle is consumed.

## Structure
- Package prbs_pkg holds:
  - state encoding localparams: SEED = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2;
  - the default tap mask 8'b10101000;
  - the default N.
- One sub-module, sat_counter (parameter W; ports clk, reset, clr, inc, q), instantiated for err_count, bit_count and relock_count.
- The FSM, predictor and run/tally counters live in prbs_checker.

## Test plan
- Reset, then feed a clean generator stream (register seeded 8'h01, valid every cycle) -> locked rises on accepted bit 25; err_count = 0; bit_count = 100 after 100 further bits.
- Locked, flip one bit -> exactly one err_pulse, err_count = 1, locked stays high; after 64 clean bits the tally is clear.
- Locked, flip 4 bits within 20 bits -> locked falls the cycle after the 4th flip, relock_count = 1; relocks 24 bits later.
- All-zero input stream -> locked never rises, state cycles SEED/VERIFY, counters stay 0.
- Gap bit_valid to 0 for 10 cycles mid-VERIFY, then resume the clean stream -> lock delayed by exactly 10 cycles with no false mismatch.
- clear asserted together with an error pulse -> err_count = 1. Force bit_count to all-ones (CNT_W = 4, 20 bits) -> holds 15.
